// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial add/subtract, one bit per clock; flags built only with SERIAL_ADDER_FLAGS_EN
module serial_adder_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, result_q;
  logic [WIDTH-2:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q;
  logic             s_d, carry_d, last_d;
  logic [WIDTH-1:0] sum_d;
  assign s_d     = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign carry_d = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
  assign sum_d   = {s_d, sum_q};
  assign last_d  = cnt_q == CW'(WIDTH - 1);
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic cout_q, overflow_q, zero_q, negative_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;
`else
  assign cout     = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            opa_q   <= a;
            opb_q   <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q <= carry_d;
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          sum_q   <= sum_d[WIDTH-1:1];
          cnt_q   <= cnt_q + 1'b1;
          if (last_d) begin
            result_q <= sum_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
`ifdef SERIAL_ADDER_FLAGS_EN
            // carry_q here is the carry into the MSB slice
            cout_q     <= carry_d;
            overflow_q <= carry_q ^ carry_d;
            zero_q     <= sum_d == '0;
            negative_q <= s_d;
`endif
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_unit.sv
// tb_serial_adder_unit: directed checks of latency, results, flags, busy protection and reset abort
module tb_serial_adder_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, sub = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        busy, done, cout, overflow, zero, negative;
  logic [63:0] result;
  int          checks = 0, errors = 0, cyc = 0;
`ifdef SERIAL_ADDER_FLAGS_EN
  localparam logic [3:0] FL = 4'hF;
`else
  localparam logic [3:0] FL = 4'h0;
`endif
  serial_adder_unit #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero), .negative(negative)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int k, output int nb);
    k = 0;
    nb = 0;
    while (!done && k < 200) begin
      nb += int'(busy);
      @(negedge clk);
      k++;
    end
    nb += int'(busy);
  endtask
  task automatic check_res(input string tag, input logic [63:0] er, input logic [3:0] ef);
    check({tag, "_result"}, result, er);
    check({tag, "_flags"}, {cout, overflow, zero, negative}, ef & FL);
  endtask
  task automatic do_op(input string tag, input logic [63:0] va, input logic [63:0] vb, input logic vs,
                       input logic [63:0] er, input logic [3:0] ef);
    int k, nb;
    @(negedge clk);
    a = va; b = vb; sub = vs; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~va; b = '0; sub = ~vs;
    wait_done(k, nb);
    check({tag, "_latency"}, 64'(k), 64'd64);
    check({tag, "_busy_cycles"}, 64'(nb), 64'd65);
    check_res(tag, er, ef);
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
  endtask
  initial begin
    int k, nb, t1, t2, nd;
    repeat (2) @(negedge clk);
    check("reset_ctl", {62'd0, done, busy}, 64'd0);
    check_res("reset", 64'd0, 4'h0);
    reset = 1'b0;
    // flags are {cout, overflow, zero, negative}
    do_op("add", 64'd5, 64'd3, 1'b0, 64'd8, 4'b0000);
    do_op("sub_neg", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001);
    do_op("sub_pos", 64'd5, 64'd3, 1'b1, 64'd2, 4'b1000);
    do_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b0101);
    do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b1010);
    do_op("sub_zero", 64'd0, 64'd0, 1'b1, 64'd0, 4'b1010);
    do_op("sub_min", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
    @(negedge clk);
    a = 64'd5; b = 64'd3; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 64'd100; b = 64'd1;
    wait_done(k, nb);
    t1 = cyc;
    check("busy_latency", 64'(k), 64'd64);
    check("busy_result", result, 64'd8);
    @(negedge clk);
    check("busy_single_done", {62'd0, done, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done(k, nb);
    t2 = cyc;
    check("b2b_period", 64'(t2 - t1), 64'd66);
    check("b2b_result", result, 64'd101);
    @(negedge clk);
    a = 64'd7; b = 64'd9; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ctl", {62'd0, done, busy}, 64'd0);
    check_res("abort", 64'd0, 4'h0);
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("abort_no_done", 64'(nd), 64'd0);
    do_op("after_abort", 64'h1234, 64'h1111, 1'b0, 64'h2345, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
